// File: rtl/cb_uart_pkg.sv
// Shared UART definitions used by the transmitter and the existing receiver.
package cb_uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned FRAME_BITS           = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/cb_baud_tick.sv
// Bit-period counter: one-cycle strobe on the last clock of each bit, held at zero while disabled.
module cb_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cb_uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register and back-to-back frame support.
module cb_uart_tx
    import cb_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       uart_tx
);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [2:0]  idx_q, idx_d;
    logic        line_q, line_d;
    logic        busy_q, busy_d;
    logic        bit_end;
    logic        load;

    cb_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i (CLK),
        .rst_ni(reset_n),
        .en_i  (state_q != ST_IDLE),
        .tick_o(bit_end)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        idx_d       = idx_q;
        load        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
        end
        // Load and accept are exclusive: load needs hold_full, accept needs it clear.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE:  line_d = IDLE_LEVEL;
            ST_START: line_d = 1'b0;
            ST_DATA:  line_d = shift_q[idx_q];
            ST_STOP:  line_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            idx_q       <= '0;
            line_q      <= IDLE_LEVEL;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_ready = ~hold_full_q;
    assign tx_busy  = busy_q;
    assign uart_tx  = line_q;

endmodule

// File: tb/tb_cb_uart_tx.sv
// Directed bench for cb_uart_tx: a CLKS_PER_BIT=4 instance and a default-rate instance.
module tb_cb_uart_tx;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       tx_ready_a, tx_ready_b;
    logic       tx_busy_a, tx_busy_b;
    logic       uart_tx_a, uart_tx_b;

    int n_tests = 0;
    int n_fail  = 0;

    cb_uart_tx #(.CLKS_PER_BIT(4), .IDLE_LEVEL(1'b1)) u_dut_a (
        .CLK(CLK), .reset_n(reset_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .tx_busy(tx_busy_a), .uart_tx(uart_tx_a)
    );

    cb_uart_tx #(.CLKS_PER_BIT(868), .IDLE_LEVEL(1'b1)) u_dut_b (
        .CLK(CLK), .reset_n(reset_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .tx_busy(tx_busy_b), .uart_tx(uart_tx_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input bit sel);
        return sel ? uart_tx_b : uart_tx_a;
    endfunction
    function automatic logic busy_of(input bit sel);
        return sel ? tx_busy_b : tx_busy_a;
    endfunction
    function automatic logic ready_of(input bit sel);
        return sel ? tx_ready_b : tx_ready_a;
    endfunction

    // Called on a negedge; returns on the negedge right after the accept edge.
    task automatic send_byte(input bit sel, input logic [7:0] b);
        if (sel) begin tx_valid_b = 1'b1; tx_data_b = b; end
        else     begin tx_valid_a = 1'b1; tx_data_a = b; end
        @(negedge CLK);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic wait_start(input bit sel, input int limit, output int cycles);
        cycles = 0;
        while (line_of(sel) !== 1'b0 && cycles < limit) begin
            @(negedge CLK);
            cycles++;
        end
        check("start_seen", {31'd0, line_of(sel)}, 32'd0);
    endtask

    // Samples every cycle of one frame starting at the current negedge.
    task automatic expect_frame(input bit sel, input int clks, input logic [7:0] b,
                                input string tag, output int rdy_hi);
        logic [9:0] fb;
        int mis_line, mis_busy;
        fb = {1'b1, b, 1'b0};
        mis_line = 0; mis_busy = 0; rdy_hi = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < clks; c++) begin
                if (line_of(sel) !== fb[i]) mis_line++;
                if (busy_of(sel) !== 1'b1) mis_busy++;
                if (ready_of(sel) === 1'b1) rdy_hi++;
                @(negedge CLK);
            end
        end
        check({tag, "_line"}, mis_line, 0);
        check({tag, "_busy"}, mis_busy, 0);
    endtask

    task automatic expect_idle(input bit sel, input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (line_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0) bad++;
            @(negedge CLK);
        end
        check(tag, bad, 0);
    endtask

    task automatic test_hold_full();
        int rh1, rh2, rh3, k, guard, cyc;
        logic acc;
        fork
            begin
                k = 0; guard = 0;
                tx_data_a = 8'h01; tx_valid_a = 1'b1;
                while (k < 3 && guard < 400) begin
                    acc = tx_ready_a;
                    @(negedge CLK);
                    guard++;
                    if (acc) begin
                        k++;
                        if (k == 1) tx_data_a = 8'h02;
                        else if (k == 2) tx_data_a = 8'h03;
                    end
                end
                tx_valid_a = 1'b0;
                check("hold_accepts", k, 3);
            end
            begin
                wait_start(0, 20, cyc);
                expect_frame(0, 4, 8'h01, "hold_f01", rh1);
                expect_frame(0, 4, 8'h02, "hold_f02", rh2);
                expect_frame(0, 4, 8'h03, "hold_f03", rh3);
            end
        join
        expect_idle(0, 60, "hold_no_dup");
    endtask

    task automatic test_ignore_busy();
        int rh, bad;
        send_byte(0, 8'h11);
        @(negedge CLK);
        tx_valid_a = 1'b1; tx_data_a = 8'h5A;
        @(negedge CLK);
        tx_valid_a = 1'b0;
        fork
            begin
                expect_frame(0, 4, 8'h11, "ign_f11", rh);
                expect_frame(0, 4, 8'h5A, "ign_f5a", rh);
            end
            begin
                bad = 0;
                for (int i = 0; i < 30; i++) begin
                    tx_valid_a = 1'($urandom);
                    tx_data_a  = 8'($urandom);
                    if (tx_ready_a !== 1'b0) bad++;
                    @(negedge CLK);
                end
                tx_valid_a = 1'b0;
                check("ign_ready_low", bad, 0);
            end
        join
        expect_idle(0, 60, "ign_no_extra");
    endtask

    initial begin
        int cyc, rh;
        reset_n    = 1'b1;
        tx_valid_a = 1'b0; tx_valid_b = 1'b0;
        tx_data_a  = '0;   tx_data_b  = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_line", {31'd0, uart_tx_a}, 1);
        check("rst_ready", {31'd0, tx_ready_a}, 1);
        check("rst_busy", {31'd0, tx_busy_a}, 0);
        check("rst_line_b", {31'd0, uart_tx_b}, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Single byte
        send_byte(0, 8'h55);
        check("single_ready_low", {31'd0, tx_ready_a}, 0);
        wait_start(0, 20, cyc);
        check("single_latency", cyc, 2);
        expect_frame(0, 4, 8'h55, "single_f55", rh);
        check("single_ready_hi", rh, 40);
        expect_idle(0, 5, "single_idle");

        // Back-to-back
        send_byte(0, 8'hA5);
        check("b2b_ready_after_load", {31'd0, tx_ready_a}, 0);
        @(negedge CLK);
        check("b2b_ready_free", {31'd0, tx_ready_a}, 1);
        tx_valid_a = 1'b1; tx_data_a = 8'h3C;
        @(negedge CLK);
        tx_valid_a = 1'b0;
        check("b2b_ready_held", {31'd0, tx_ready_a}, 0);
        expect_frame(0, 4, 8'hA5, "b2b_fa5", rh);
        check("b2b_ready_until_load", rh, 1);
        expect_frame(0, 4, 8'h3C, "b2b_f3c", rh);
        check("b2b_ready_second", rh, 40);
        expect_idle(0, 5, "b2b_idle");

        test_hold_full();
        test_ignore_busy();

        // Reset mid-frame with a byte waiting in the holding register
        send_byte(0, 8'hFF);
        @(negedge CLK);
        tx_valid_a = 1'b1; tx_data_a = 8'h42;
        @(negedge CLK);
        tx_valid_a = 1'b0;
        repeat (16) @(negedge CLK);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_line", {31'd0, uart_tx_a}, 1);
        check("rst_mid_ready", {31'd0, tx_ready_a}, 1);
        check("rst_mid_busy", {31'd0, tx_busy_a}, 0);
        @(negedge CLK);
        reset_n = 1'b1;
        expect_idle(0, 50, "rst_discard");
        send_byte(0, 8'h80);
        wait_start(0, 20, cyc);
        check("rst_after_latency", cyc, 2);
        expect_frame(0, 4, 8'h80, "rst_f80", rh);
        expect_idle(0, 5, "rst_after_idle");

        // Default bit rate
        send_byte(1, 8'h0D);
        wait_start(1, 20, cyc);
        check("slow_latency", cyc, 2);
        expect_frame(1, 868, 8'h0D, "slow_f0d", rh);
        check("slow_ready_hi", rh, 8680);
        expect_idle(1, 10, "slow_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cb_uart_tx.md
CB_UART_TX -- requirements
Module: cb_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, CLK cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter IDLE_LEVEL, default 1'b1, line level when no frame is in flight.
REQ-003 Port CLK  input  1  system clock; all state on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port tx_data  input  8  byte to send, LSB first.
REQ-006 Port tx_valid  input  1  tx_data valid this cycle.
REQ-007 Port tx_ready  output  1  holding register empty; a byte is accepted when tx_valid && tx_ready.
REQ-008 Port tx_busy  output  1  frame currently on the line.
REQ-009 Port uart_tx  output  1  serial line (8N1), registered.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE: uart_tx = IDLE_LEVEL, tx_busy = 0; if holding register full, move byte to shift register and enter START next cycle.
REQ-013 START: uart_tx = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-014 DATA: uart_tx = shift[bit index]; after CLKS_PER_BIT cycles increment index; after index 7 completes, enter STOP.
REQ-015 STOP: uart_tx = 1 for CLKS_PER_BIT cycles; at last cycle, if holding register full, load it and enter START directly (no idle gap), else IDLE.
REQ-016 One-entry holding register: tx_ready = ~hold_full; accept captures tx_data and sets hold_full on the accept edge.
REQ-017 Accept latency: byte accepted while IDLE with empty shift register drives uart_tx low on cycle 2 after the accept edge (1 cycle hold, 1 cycle load/register).
REQ-018 hold_full SHALL clear on the cycle the byte is moved to the shift register; a new accept in that same cycle is not possible (tx_ready was 0).
REQ-019 tx_valid while tx_ready = 0 SHALL be ignored; tx_data need not be stable and is not sampled.
REQ-020 Baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, reload 0 at every bit boundary, terminal count CLKS_PER_BIT-1; bit index 3 bits, no wrap beyond 7.
REQ-021 tx_busy = 1 in START, DATA, STOP.
REQ-022 uart_tx SHALL be glitch-free (driven from a flop).

Reset
REQ-023 reset_n low SHALL asynchronously force: state IDLE, uart_tx = IDLE_LEVEL, tx_busy = 0, tx_ready = 1, hold_full = 0, counters 0.
REQ-024 Reset mid-frame SHALL abort the frame immediately and discard held byte; deassertion is synchronised by the system reset bridge, block restarts in IDLE.

Structure
REQ-025 Shared package cb_uart_pkg SHALL hold the state enum, DEFAULT_CLKS_PER_BIT (868), frame bit count (10) — shared with the existing receiver.
REQ-026 One sub-module natural: cb_baud_tick (counter producing a one-cycle bit-end strobe, restartable); rest is flat.

Verification (CLKS_PER_BIT = 4 unless stated)
REQ-027 Single byte 0x55 from IDLE -> uart_tx 0,1,0,1,0,1,0,1,0,1 each 4 cycles, line low 2 cycles after accept, tx_busy high 40 cycles.
REQ-028 Back-to-back 0xA5 then 0x3C (second offered during first frame) -> two contiguous 40-cycle frames, no idle cycle between stop and start; tx_ready low from second accept until its load.
REQ-029 Holding full: offer 0x01, 0x02, 0x03 consecutively with valid held -> 0x03 accepted only after 0x02 loads; line shows 0x01,0x02,0x03 in order, none lost or duplicated.
REQ-030 Reset at cycle 17 of a 0xFF frame -> uart_tx = 1, tx_ready = 1, tx_busy = 0 same cycle (async); next byte 0x80 sent as a clean frame.
REQ-031 CLKS_PER_BIT = 868, byte 0x0D -> each bit width measured 868 cycles ±0, frame 8680 cycles.
REQ-032 tx_valid toggled with random tx_data while tx_ready = 0 -> no change to the queued byte.
